// File: rtl/multi_sng.sv
// Multi-channel stochastic number generator: one shared Galois LFSR feeds CH
// comparators, each seeing a different rotation of the LFSR word.

module multi_sng_lane #(
  parameter int N  = 16,
  parameter int SH = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [N-1:0] i_thr,
  input  logic [N-1:0] i_lfsr,
  input  logic         i_en,
  output logic         o_bit
);
  logic [N-1:0]   r_thr;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Rotate-left by SH picked straight out of the doubled word.
  assign w_dbl = {i_lfsr, i_lfsr};
  assign w_rot = w_dbl[N-SH +: N];
  assign o_bit = i_en && (w_rot < r_thr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_thr <= '0;
    else if (i_load) r_thr <= i_thr;
  end
endmodule

module multi_sng #(
  parameter int           N    = 16,
  parameter int           SEED = 1,
  parameter logic [N-1:0] TAPS = N'(16'hB400),
  parameter int           CH   = 4,
  parameter int           LEN  = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CH*N-1:0] cfg_data,
  input  logic          start,
  input  logic          reseed,
  input  logic          abort,
  output logic          busy,
  output logic          bits_valid,
  output logic [CH-1:0] bits,
  output logic          done
);
  localparam int           CW      = $clog2(LEN);
  localparam logic [N-1:0] SEED_N  = N'(SEED);
  localparam logic [N-1:0] SEED_EF = (SEED_N == '0) ? N'(1) : SEED_N;
  localparam logic [CW-1:0] LAST   = CW'(LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_lfsr;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  w_step, w_lfsr_nxt;
  logic          w_last, w_load;

  assign w_step     = {1'b0, r_lfsr[N-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
  // A degenerate mask could collapse the register to zero; fall back to the seed.
  assign w_lfsr_nxt = (w_step == '0) ? SEED_EF : w_step;
  assign w_last     = (r_cnt == LAST);

  assign busy       = (r_state == RUN);
  assign bits_valid = busy;
  assign cfg_ready  = (r_state == IDLE);
  assign done       = busy && w_last;
  assign w_load     = cfg_valid && cfg_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN:  if (w_last || abort) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED_EF;
      r_cnt  <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_cnt <= '0;
        if (reseed) r_lfsr <= SEED_EF;
      end
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      multi_sng_lane #(.N(N), .SH((gi * (N / CH)) % N)) u_lane (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_thr  (cfg_data[gi*N +: N]),
        .i_lfsr (r_lfsr),
        .i_en   (busy),
        .o_bit  (bits[gi])
      );
    end
  endgenerate
endmodule
